// File: rtl/dot_stream_loader.sv
// Stream loader for the 8-lane signed dot-product accelerator: gathers operand
// pairs into banks, fires the accelerator, and returns its result (or a timeout).
module dot_stream_loader #(
    parameter int N              = 8,
    parameter int DW             = 32,
    parameter int RW             = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    input  logic            in_last,
    output logic            acc_start,
    output logic [N*DW-1:0] acc_a,
    output logic [N*DW-1:0] acc_b,
    input  logic            acc_done,
    input  logic [RW-1:0]   acc_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_result,
    output logic            out_timeout,
    output logic            busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_FILL, S_FIRE, S_WAIT, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   res_q, res_d;
    logic            tmo_q, tmo_d;
    logic            done_q;
    logic            accept;
    logic            clear_banks;
    logic            completion;

    assign accept      = in_valid && (state_q == S_FILL);
    assign clear_banks = (state_q == S_DRAIN) && out_ready;
    // Only a rising edge counts, so a level left high from an earlier frame is ignored.
    assign completion  = acc_done && !done_q;

    assign in_ready    = (state_q == S_FILL);
    assign acc_start   = (state_q == S_FIRE);
    assign out_valid   = (state_q == S_DRAIN);
    assign busy        = (state_q != S_FILL);
    assign out_result  = res_q;
    assign out_timeout = tmo_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST || in_last) begin
                        state_d = S_FIRE;
                    end
                end
            end
            S_FIRE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (completion) begin
                    res_d   = acc_result;
                    tmo_d   = 1'b0;
                    state_d = S_DRAIN;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == T_LAST) begin
                    res_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            idx_q   <= '0;
            timer_q <= '0;
            res_q   <= '0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
            done_q  <= acc_done;
        end
    end

    // Banks clear on the output handshake so a short frame leaves upper lanes at zero.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [DW-1:0] a_lane_q;
            logic [DW-1:0] b_lane_q;
            always_ff @(posedge clk) begin
                if (rst || clear_banks) begin
                    a_lane_q <= '0;
                    b_lane_q <= '0;
                end else if (accept && idx_q == IW'(gi)) begin
                    a_lane_q <= in_a;
                    b_lane_q <= in_b;
                end
            end
            assign acc_a[gi*DW +: DW] = a_lane_q;
            assign acc_b[gi*DW +: DW] = b_lane_q;
        end
    endgenerate
endmodule

// File: tb/tb_dot_stream_loader.sv
// Directed bench for dot_stream_loader with a behavioural accelerator and stuck-done stubs.
module tb_dot_stream_loader;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int RW  = 64;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic            in_last;
    logic            acc_start;
    logic [N*DW-1:0] acc_a;
    logic [N*DW-1:0] acc_b;
    logic            acc_done;
    logic [RW-1:0]   acc_result;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   out_result;
    logic            out_timeout;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fire_cyc = 0;
    int valid_cyc = 0;
    int mode = 0;          // 0 = behavioural accelerator, 1 = done stuck 0, 2 = done stuck 1
    logic signed [DW-1:0] fa [N];
    logic signed [DW-1:0] fb [N];

    logic                 acc_pulse = 1'b0;
    logic signed [RW-1:0] model_res = '0;
    int                   lat_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot_stream_loader #(.N(N), .DW(DW), .RW(RW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .acc_start(acc_start), .acc_a(acc_a), .acc_b(acc_b),
        .acc_done(acc_done), .acc_result(acc_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_timeout(out_timeout), .busy(busy)
    );

    function automatic logic signed [RW-1:0] dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        logic signed [RW-1:0] s;
        logic signed [RW-1:0] x;
        logic signed [RW-1:0] y;
        s = '0;
        for (int i = 0; i < N; i++) begin
            x = signed'(a[i*DW +: DW]);
            y = signed'(b[i*DW +: DW]);
            s += x * y;
        end
        return s;
    endfunction

    // Accelerator: samples the banks on acc_start, pulses done four cycles later.
    always @(posedge clk) begin
        acc_pulse <= 1'b0;
        if (acc_start) begin
            model_res <= dot(acc_a, acc_b);
            lat_cnt   <= 4;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) acc_pulse <= 1'b1;
        end
    end
    assign acc_done   = (mode == 0) ? acc_pulse : (mode == 2);
    assign acc_result = (mode == 0) ? model_res : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic check(input string tag, input logic signed [RW-1:0] obs, input logic signed [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int cnt, input logic use_last);
        for (int i = 0; i < cnt; i++) begin
            send_beat(fa[i], fb[i], (i == cnt - 1) && use_last);
        end
        check("acc_start_latency", acc_start, 1);
        check("busy_fire", busy, 1);
        fire_cyc = cyc;
        @(posedge clk);
        #1;
        check("acc_start_one_cycle", acc_start, 0);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", out_valid, 1);
        valid_cyc = cyc;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_exit_valid", out_valid, 0);
        check("drain_exit_in_ready", in_ready, 1);
    endtask

    task automatic load_t1();
        for (int i = 0; i < N; i++) begin
            fa[i] = DW'(i + 1);
            fb[i] = (i < 4) ? 32'sd10 : 32'sd1;
        end
    endtask

    task automatic load_t2();
        fa = '{32'sd10, -32'sd5, 32'sd100, -32'sd1, 32'sd0, 32'sd20, -32'sd2, 32'sd1};
        fb = '{32'sd2, 32'sd10, -32'sd1, 32'sd20, 32'sd50, -32'sd5, 32'sd4, -32'sd8};
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_acc_start"}, acc_start, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_timeout"}, out_timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_result"}, out_result, 0);
        check({tag, "_banks_zero"}, ((acc_a === '0) && (acc_b === '0)), 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // T1: full frame with last on beat 8
        load_t1();
        send_frame(8, 1'b1);
        wait_result();
        check("t1_result", out_result, 126);
        check("t1_timeout", out_timeout, 0);
        handshake();
        $display("T1 result=%0d timeout=%0b", $signed(out_result), out_timeout);

        // T3: short frame, upper lanes must be cleared from T1
        fa[0] = 32'sd2;  fb[0] = 32'sd3;
        fa[1] = 32'sd4;  fb[1] = 32'sd5;
        fa[2] = -32'sd1; fb[2] = 32'sd7;
        send_frame(3, 1'b1);
        check("t3_lane2_a_sign", acc_a[2*DW +: DW], 32'hFFFF_FFFF);
        check("t3_upper_a_zero", acc_a[N*DW-1:3*DW], 0);
        check("t3_upper_b_zero", acc_b[N*DW-1:3*DW], 0);
        wait_result();
        check("t3_result", out_result, 19);
        handshake();
        $display("T3 result=%0d", $signed(out_result));

        // T4: out_ready held low, result and banks stay put, input stalls
        load_t1();
        send_frame(8, 1'b1);
        wait_result();
        in_valid = 1'b1; in_a = 32'd99; in_b = 32'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid_held", out_valid, 1);
            check("t4_result_stable", out_result, 126);
            check("t4_in_ready_low", in_ready, 0);
            check("t4_lane0_held", acc_a[DW-1:0], 1);
        end
        in_valid = 1'b0;
        handshake();
        $display("T4 result=%0d held 5 cycles", $signed(out_result));

        // T5: stuck-done stubs must time out 16 cycles after WAIT starts
        for (int m = 1; m <= 2; m++) begin
            mode = m;
            load_t1();
            send_frame(8, 1'b1);
            wait_result();
            check("t5_timeout_latency", valid_cyc - fire_cyc, 1 + TMO);
            check("t5_result_zero", out_result, 0);
            check("t5_timeout_flag", out_timeout, 1);
            handshake();
            $display("T5 mode=%0d latency=%0d timeout=%0b", m, valid_cyc - fire_cyc, out_timeout);
        end
        mode = 0;
        repeat (2) @(posedge clk);

        // T2: signed frame; beat 8 carries no last
        load_t2();
        send_frame(8, 1'b0);
        wait_result();
        check("t2_result", out_result, -266);
        check("t2_timeout_cleared", out_timeout, 0);
        handshake();
        $display("T2 result=%0d", $signed(out_result));

        // T6: reset mid-WAIT discards the frame, then T2 again
        load_t2();
        send_frame(8, 1'b1);
        check("t6_in_wait_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("t6_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        send_frame(8, 1'b1);
        wait_result();
        check("t6_result", out_result, -266);
        handshake();
        $display("T6 result=%0d", $signed(out_result));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
